// File: rtl/pmod_cls_text_writer_gen_if.sv
// pmod_generic_spi_solo_intf: handshake between a byte-stream driver and the generic SPI solo master
interface pmod_generic_spi_solo_intf;
  logic [7:0] tx_data;
  logic       tx_enqueue;
  logic [7:0] tx_len;
  logic [7:0] rx_len;
  logic [7:0] wait_cyc;
  logic       rx_dequeue;
  logic       go_stand;
  logic       tx_ready;
  logic       spi_idle;
  modport spi_sysdrv (
    output tx_data, tx_enqueue, tx_len, rx_len, wait_cyc, rx_dequeue, go_stand,
    input  tx_ready, spi_idle
  );
  modport spi_solo (
    input  tx_data, tx_enqueue, tx_len, rx_len, wait_cyc, rx_dequeue, go_stand,
    output tx_ready, spi_idle
  );
endinterface

// File: rtl/pmod_cls_text_writer_gen.sv
// pmod_cls_text_writer_gen: CLS-protocol text writer (clear / positioned write) over a generic SPI solo master
module pmod_cls_text_writer_gen #(
  parameter bit parm_fast_simulation = 1'b0,
  parameter int FCLK = 20000000,
  parameter int FCLK_ce = 2500000,
  parameter int PARM_LINES = 2,
  parameter int PARM_COLS = 16,
  parameter int PARM_BOOT_MS = 800,
  parameter int PARM_CLEAR_GUARD_US = 1000
) (
  input  logic                   i_ext_spi_clk_x,
  input  logic                   i_srst,
  input  logic                   i_spi_ce_4x,
  pmod_generic_spi_solo_intf.spi_sysdrv sdrv,
  output logic                   o_command_ready,
  output logic                   o_busy,
  output logic                   o_err_cmd,
  input  logic                   i_cmd_valid,
  input  logic [1:0]             i_cmd_op,
  input  logic [1:0]             i_cmd_row,
  input  logic [5:0]             i_cmd_col,
  input  logic [5:0]             i_cmd_len,
  input  logic [PARM_COLS*8-1:0] i_dat_text
);
  localparam int BOOT_N = FCLK_ce / 1000 * (parm_fast_simulation ? 2 : PARM_BOOT_MS);
  localparam int GUARD_N = FCLK_ce / 1000 * (parm_fast_simulation ? 10 : PARM_CLEAR_GUARD_US) / 1000;
  localparam int TW = $clog2(BOOT_N > GUARD_N ? BOOT_N : GUARD_N);
  localparam int TXW = PARM_COLS * 8;
  localparam logic [2:0] LINES3 = 3'(PARM_LINES);
  localparam logic [6:0] COLS7 = 7'(PARM_COLS);
  if (FCLK_ce > FCLK || PARM_LINES < 1 || PARM_LINES > 4 || PARM_COLS < 8 || PARM_COLS > 40) begin : g_bad_params
    $error("pmod_cls_text_writer_gen: parameter out of range");
  end
  typedef enum logic [3:0] {
    S_BOOT, S_IDLE, S_LOAD_CLEAR, S_LOAD_WRITE, S_CMD_RUN, S_CMD_WAIT, S_DAT_RUN, S_DAT_WAIT, S_GUARD
  } state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0] row_q, row_d;
  logic [5:0] col_q, col_d, len_q, len_d;
  logic [TXW-1:0] text_q, text_d;
  logic [55:0] cmd_q, cmd_d;
  logic [6:0] cmd_len_q, cmd_len_d, eff_len_q, eff_len_d, idx_q, idx_d;
  logic clr_q, clr_d;
  logic [7:0] tens, ones;
  logic [6:0] room, eff;
  assign tens = col_q >= 6'd30 ? 8'h33 : col_q >= 6'd20 ? 8'h32 : col_q >= 6'd10 ? 8'h31 : 8'h30;
  assign ones = 8'h30 + {2'b0, col_q - (col_q >= 6'd30 ? 6'd30 : col_q >= 6'd20 ? 6'd20 : col_q >= 6'd10 ? 6'd10 : 6'd0)};
  assign room = COLS7 - {1'b0, col_q};
  assign eff = {1'b0, len_q} > room ? room : {1'b0, len_q};
  // next-state, command/text sequencing and handshake outputs
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    len_d = len_q;
    text_d = text_q;
    cmd_d = cmd_q;
    cmd_len_d = cmd_len_q;
    eff_len_d = eff_len_q;
    idx_d = idx_q;
    clr_d = clr_q;
    o_command_ready = 1'b0;
    o_busy = 1'b1;
    o_err_cmd = 1'b0;
    sdrv.tx_data = '0;
    sdrv.tx_enqueue = 1'b0;
    sdrv.tx_len = '0;
    sdrv.rx_len = '0;
    sdrv.wait_cyc = '0;
    sdrv.rx_dequeue = 1'b0;
    sdrv.go_stand = 1'b0;
    case (state_q)
      S_BOOT: if (timer_q == TW'(BOOT_N - 1)) state_d = S_IDLE;
      S_IDLE: begin
        o_command_ready = 1'b1;
        o_busy = 1'b0;
        if (i_cmd_valid) begin
          row_d = i_cmd_row;
          col_d = i_cmd_col;
          len_d = i_cmd_len;
          text_d = i_dat_text;
          if (i_cmd_op == 2'b00) state_d = S_LOAD_CLEAR;
          else if (i_cmd_op == 2'b01 && {1'b0, i_cmd_row} < LINES3 && {1'b0, i_cmd_col} < COLS7) state_d = S_LOAD_WRITE;
          else o_err_cmd = i_spi_ce_4x;
        end
      end
      S_LOAD_CLEAR: begin
        cmd_d = {32'h1B5B306A, 24'h0};
        cmd_len_d = 7'd4;
        eff_len_d = '0;
        idx_d = '0;
        clr_d = 1'b1;
        state_d = S_CMD_RUN;
      end
      S_LOAD_WRITE: begin
        cmd_d = {16'h1B5B, 8'h30 + {6'b0, row_q}, 8'h3B, tens, ones, 8'h48};
        cmd_len_d = 7'd7;
        eff_len_d = eff;
        idx_d = '0;
        clr_d = 1'b0;
        state_d = S_CMD_RUN;
      end
      S_CMD_RUN: begin
        sdrv.tx_len = {1'b0, cmd_len_q};
        sdrv.tx_data = cmd_q[55:48];
        if (sdrv.tx_ready) begin
          sdrv.tx_enqueue = i_spi_ce_4x;
          cmd_d = cmd_q << 8;
          idx_d = idx_q + 7'd1;
          if (idx_q + 7'd1 == cmd_len_q) begin
            sdrv.go_stand = i_spi_ce_4x;
            idx_d = '0;
            state_d = S_CMD_WAIT;
          end
        end
      end
      S_CMD_WAIT: if (sdrv.spi_idle) state_d = eff_len_q != '0 ? S_DAT_RUN : clr_q ? S_GUARD : S_IDLE;
      S_DAT_RUN: begin
        sdrv.tx_len = {1'b0, eff_len_q};
        sdrv.tx_data = text_q[TXW-1 -: 8];
        if (sdrv.tx_ready) begin
          sdrv.tx_enqueue = i_spi_ce_4x;
          text_d = text_q << 8;
          idx_d = idx_q + 7'd1;
          if (idx_q + 7'd1 == eff_len_q) begin
            sdrv.go_stand = i_spi_ce_4x;
            idx_d = '0;
            state_d = S_DAT_WAIT;
          end
        end
      end
      S_DAT_WAIT: if (sdrv.spi_idle) state_d = S_IDLE;
      S_GUARD: if (timer_q == TW'(GUARD_N - 1)) state_d = S_IDLE;
      default: state_d = S_BOOT;
    endcase
  end
  assign timer_d = state_d != state_q ? '0 : timer_q + 1'b1;
  // all state advances only on enabled cycles
  always_ff @(posedge i_ext_spi_clk_x or posedge i_srst)
    if (i_srst) begin
      state_q <= S_BOOT;
      timer_q <= '0;
      row_q <= '0;
      col_q <= '0;
      len_q <= '0;
      text_q <= '0;
      cmd_q <= '0;
      cmd_len_q <= '0;
      eff_len_q <= '0;
      idx_q <= '0;
      clr_q <= 1'b0;
    end else if (i_spi_ce_4x) begin
      state_q <= state_d;
      timer_q <= timer_d;
      row_q <= row_d;
      col_q <= col_d;
      len_q <= len_d;
      text_q <= text_d;
      cmd_q <= cmd_d;
      cmd_len_q <= cmd_len_d;
      eff_len_q <= eff_len_d;
      idx_q <= idx_d;
      clr_q <= clr_d;
    end
endmodule

// File: tb/tb_pmod_cls_text_writer_gen.sv
// tb_pmod_cls_text_writer_gen: directed vector bench for the CLS text writer
module tb_pmod_cls_text_writer_gen;
  logic clk, rst, ce;
  logic o_command_ready, o_busy, o_err_cmd;
  logic i_cmd_valid;
  logic [1:0] i_cmd_op, i_cmd_row;
  logic [5:0] i_cmd_col, i_cmd_len;
  logic [127:0] i_dat_text;
  logic [127:0] txt;
  int n_cmp, n_bad;
  typedef struct {
    string name;
    logic [1:0] op;
    logic [1:0] row;
    logic [5:0] col;
    logic [5:0] len;
    logic [55:0] cmd;
    int cmd_n;
    int dat_n;
    bit err;
  } vec_t;
  vec_t vt[12];
  pmod_generic_spi_solo_intf sif();
  pmod_cls_text_writer_gen #(.parm_fast_simulation(1'b1)) dut (
    .i_ext_spi_clk_x(clk),
    .i_srst(rst),
    .i_spi_ce_4x(ce),
    .sdrv(sif),
    .o_command_ready(o_command_ready),
    .o_busy(o_busy),
    .o_err_cmd(o_err_cmd),
    .i_cmd_valid(i_cmd_valid),
    .i_cmd_op(i_cmd_op),
    .i_cmd_row(i_cmd_row),
    .i_cmd_col(i_cmd_col),
    .i_cmd_len(i_cmd_len),
    .i_dat_text(i_dat_text)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  // enable high for one clock in four, straddling a rising edge
  initial begin
    ce = 0;
    #7;
    forever begin
      ce = 0;
      #30;
      ce = 1;
      #10;
    end
  end
  task automatic en();
    @(posedge ce);
    #2;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic boot_wait(input string nm);
    int k, act;
    k = 0;
    act = 0;
    while (k < 6000) begin
      en();
      k++;
      act += int'(sif.tx_enqueue | sif.go_stand);
      if (o_command_ready) break;
    end
    chk({nm, "_cycles"}, k, 5000);
    chk({nm, "_quiet"}, act, 0);
  endtask
  task automatic run_vec(input vec_t v);
    logic [7:0] got[$];
    int lens[$];
    int gos, errs, hold, first_rdy, n, exp_gos;
    bit done;
    gos = 0;
    hold = 0;
    done = 0;
    en();
    i_cmd_op = v.op;
    i_cmd_row = v.row;
    i_cmd_col = v.col;
    i_cmd_len = v.len;
    i_cmd_valid = 1;
    #1;
    chk({v.name, "_ready_at_issue"}, o_command_ready, 1);
    errs = int'(o_err_cmd);
    en();
    i_cmd_valid = 0;
    #1;
    first_rdy = int'(o_command_ready);
    for (int k = 0; k < 800 && !done; k++) begin
      errs += int'(o_err_cmd);
      if (sif.tx_enqueue) begin
        got.push_back(sif.tx_data);
        lens.push_back(int'(sif.tx_len));
        sif.spi_idle = 0;
      end
      if (sif.go_stand) begin
        gos++;
        hold = 3;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) sif.spi_idle = 1;
      end
      if (o_command_ready) done = 1;
      else begin
        en();
        #1;
      end
    end
    sif.spi_idle = 1;
    exp_gos = v.err ? 0 : v.dat_n > 0 ? 2 : 1;
    chk({v.name, "_done"}, done, 1);
    chk({v.name, "_err_pulses"}, errs, v.err);
    chk({v.name, "_ready_after"}, first_rdy, v.err);
    chk({v.name, "_nbytes"}, got.size(), v.cmd_n + v.dat_n);
    chk({v.name, "_go_stand"}, gos, exp_gos);
    n = got.size() < v.cmd_n + v.dat_n ? got.size() : v.cmd_n + v.dat_n;
    for (int j = 0; j < n; j++) begin
      if (j < v.cmd_n) begin
        chk($sformatf("%s_cmd%0d", v.name, j), got[j], v.cmd[55-8*j -: 8]);
        chk($sformatf("%s_cmdlen%0d", v.name, j), lens[j], v.cmd_n);
      end else begin
        chk($sformatf("%s_dat%0d", v.name, j - v.cmd_n), got[j], txt[127-8*(j-v.cmd_n) -: 8]);
        chk($sformatf("%s_datlen%0d", v.name, j - v.cmd_n), lens[j], v.dat_n);
      end
    end
  endtask
  initial begin
    int k, cnt;
    bit gs;
    n_cmp = 0;
    n_bad = 0;
    txt = "ABCDEFGHIJKLMNOP";
    vt[0]  = '{"clear",       2'd0, 2'd0, 6'd0,  6'd0,  56'h1B5B306A000000, 4, 0,  1'b0};
    vt[1]  = '{"wr_r1c5",     2'd1, 2'd1, 6'd5,  6'd4,  56'h1B5B313B303548, 7, 4,  1'b0};
    vt[2]  = '{"trunc_c14",   2'd1, 2'd0, 6'd14, 6'd8,  56'h1B5B303B313448, 7, 2,  1'b0};
    vt[3]  = '{"len0_c12",    2'd1, 2'd0, 6'd12, 6'd0,  56'h1B5B303B313248, 7, 0,  1'b0};
    vt[4]  = '{"rej_row2",    2'd1, 2'd2, 6'd0,  6'd4,  56'h0,              0, 0,  1'b1};
    vt[5]  = '{"rej_op10",    2'd2, 2'd0, 6'd0,  6'd4,  56'h0,              0, 0,  1'b1};
    vt[6]  = '{"rej_op11",    2'd3, 2'd1, 6'd3,  6'd2,  56'h0,              0, 0,  1'b1};
    vt[7]  = '{"rej_col16",   2'd1, 2'd0, 6'd16, 6'd1,  56'h0,              0, 0,  1'b1};
    vt[8]  = '{"full_r1c0",   2'd1, 2'd1, 6'd0,  6'd16, 56'h1B5B313B303048, 7, 16, 1'b0};
    vt[9]  = '{"trunc_c15",   2'd1, 2'd0, 6'd15, 6'd63, 56'h1B5B303B313548, 7, 1,  1'b0};
    vt[10] = '{"wr_r1c10",    2'd1, 2'd1, 6'd10, 6'd3,  56'h1B5B313B313048, 7, 3,  1'b0};
    vt[11] = '{"fit_r0c9",    2'd1, 2'd0, 6'd9,  6'd7,  56'h1B5B303B303948, 7, 7,  1'b0};
    rst = 1;
    i_cmd_valid = 0;
    i_cmd_op = 0;
    i_cmd_row = 0;
    i_cmd_col = 0;
    i_cmd_len = 0;
    i_dat_text = txt;
    sif.tx_ready = 1;
    sif.spi_idle = 1;
    en();
    chk("rst_ready", o_command_ready, 0);
    chk("rst_busy", o_busy, 1);
    chk("rst_err", o_err_cmd, 0);
    chk("rst_sdrv", {sif.tx_data, sif.tx_enqueue, sif.tx_len, sif.rx_len, sif.wait_cyc, sif.rx_dequeue, sif.go_stand}, 0);
    rst = 0;
    boot_wait("boot");
    chk("idle_busy", o_busy, 0);
    en();
    i_cmd_op = 2'd0;
    i_cmd_valid = 1;
    en();
    i_cmd_valid = 0;
    k = 0;
    gs = 0;
    while (k < 20 && !gs) begin
      if (sif.go_stand) begin
        gs = 1;
        chk("guard_go_len", sif.tx_len, 4);
      end else begin
        en();
        k++;
      end
    end
    chk("guard_go_seen", gs, 1);
    en();
    chk("guard_wait_ready", o_command_ready, 0);
    cnt = 0;
    while (cnt < 100) begin
      en();
      if (o_command_ready) break;
      chk("guard_busy", o_busy, 1);
      cnt++;
    end
    chk("guard_cycles", cnt, 25);
    for (int i = 0; i < 12; i++) run_vec(vt[i]);
    en();
    i_cmd_op = 2'd1;
    i_cmd_row = 2'd1;
    i_cmd_col = 6'd0;
    i_cmd_len = 6'd16;
    i_cmd_valid = 1;
    en();
    i_cmd_valid = 0;
    cnt = 0;
    k = 0;
    while (k < 100 && cnt < 12) begin
      en();
      k++;
      if (sif.tx_enqueue) cnt++;
    end
    chk("mid_reached", cnt, 12);
    #10;
    rst = 1;
    #1;
    chk("mid_rst_ready", o_command_ready, 0);
    chk("mid_rst_busy", o_busy, 1);
    chk("mid_rst_txlen", sif.tx_len, 0);
    chk("mid_rst_txdata", sif.tx_data, 0);
    en();
    chk("mid_rst_enq", sif.tx_enqueue, 0);
    chk("mid_rst_go", sif.go_stand, 0);
    chk("mid_rst_txlen_ce", sif.tx_len, 0);
    rst = 0;
    boot_wait("reboot");
    run_vec(vt[1]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pmod_cls_text_writer_gen.md
Name: pmod_cls_text_writer_gen

Overview:
- Parametrised successor to the fixed 2x16 PMOD CLS SPI driver.
- Drives the PMOD CLS (or a compatible CLS-protocol display) over the shared pmod_generic_spi_solo_intf in SPI Mode 0.
- Supports configurable line count and column count, writes at an arbitrary row/column with variable length, and validates/truncates commands.
- Enforces a post-clear guard delay; sits between the application text formatter and the generic SPI solo master.

Parameters:
- parm_fast_simulation, 0, 1 shortens boot time to 2 ms and guard time to 10 us.
- FCLK, 20000000, frequency in Hz of i_ext_spi_clk_x.
- FCLK_ce, 2500000, rate in Hz of the i_spi_ce_4x enable.
- PARM_LINES, 2, display rows, 1..4.
- PARM_COLS, 16, display columns, 8..40.
- PARM_BOOT_MS, 800, boot wait in ms when not fast-simulating.
- PARM_CLEAR_GUARD_US, 1000, idle wait after a clear completes.

Ports:
- i_ext_spi_clk_x  in  1  system clock.
- i_srst  in  1  asynchronous active-high reset.
- i_spi_ce_4x  in  1  clock enable; all state, timer and handshake updates occur only on enabled cycles.
- sdrv  modport spi_sysdrv  -  tx_data[7:0], tx_enqueue, tx_len, rx_len, wait_cyc, rx_dequeue, go_stand out; tx_ready, spi_idle in.
- o_command_ready  out  1  block can accept a command.
- o_busy  out  1  command in progress, or boot/guard active.
- o_err_cmd  out  1  one-enabled-cycle pulse: command rejected.
- i_cmd_valid  in  1  command request.
- i_cmd_op  in  2  00 clear; 01 write; 10/11 rejected.
- i_cmd_row  in  2  target row.
- i_cmd_col  in  6  target column, zero-based.
- i_cmd_len  in  6  bytes to write, 0..PARM_COLS.
- i_dat_text  in  PARM_COLS*8  text; byte 0 in the MSBs.

Behaviour:
- Reset (asynchronous, any state): state to BOOT, timer 0, all aux registers 0.
  - o_command_ready=0, o_busy=1, o_err_cmd=0.
  - All sdrv outputs 0; rx_len=0, wait_cyc=0 and rx_dequeue=0 always.
- States: BOOT, IDLE, LOAD_CLEAR, LOAD_WRITE, CMD_RUN, CMD_WAIT, DAT_RUN, DAT_WAIT, GUARD.
- BOOT:
  - Timer counts enabled cycles.
  - Exits to IDLE when timer = FCLK_ce/1000*boot_ms - 1, with boot_ms = 2 if fast, else PARM_BOOT_MS.
  - Timer clears on every state change.
- IDLE:
  - o_command_ready=1, o_busy=0.
  - Accept occurs on an enabled cycle with i_cmd_valid=1; all command inputs are captured that cycle.
  - op=00 goes to LOAD_CLEAR.
  - op=01 with row<PARM_LINES and col<PARM_COLS goes to LOAD_WRITE.
  - Any other op/row/col: o_err_cmd pulses for that enabled cycle, state stays IDLE, no SPI traffic.
- LOAD_CLEAR: cmd bytes 1B 5B 30 6A, cmd_len 4, dat_len 0.
- LOAD_WRITE:
  - Cmd bytes 1B 5B (30+row) 3B (30+col/10) (30+col%10) 48, cmd_len 7.
  - eff_len = min(len, PARM_COLS-col).
  - Data bytes are i_dat_text bytes 0..eff_len-1.
- CMD_RUN:
  - tx_enqueue = tx_ready; tx_data = next cmd byte, first byte first; tx_len = cmd_len.
  - go_stand=1 coincides with the last byte's enqueue, then state goes to CMD_WAIT.
- CMD_WAIT:
  - On spi_idle: go to DAT_RUN if eff_len>0.
  - Otherwise go to GUARD if the command was a clear, else IDLE.
- DAT_RUN / DAT_WAIT: same as CMD_RUN / CMD_WAIT with tx_len = eff_len; DAT_WAIT exits to IDLE on spi_idle.
- GUARD: waits FCLK_ce/1000000*guard_us enabled cycles (guard_us = 10 if fast), then goes to IDLE.
- Write with len=0: cursor sequence only, no data phase.
- Holding i_cmd_valid high in IDLE re-issues the command after each completion; no queueing.
- Counter widths must hold the maximum boot count for the parameter set; col/10 is computed combinationally for col<=39.

Test Plan:
- Boot: fast sim, FCLK_ce=2.5 MHz -> o_command_ready rises exactly 5000 enabled cycles after reset release; no SPI activity before that.
- Clear: op=00 -> bytes 1B 5B 30 6A with tx_len=4 and go_stand on the 4th; after spi_idle, o_command_ready stays 0 for 25 enabled cycles (fast guard).
- Write: row=1, col=5, len=4, text "ABCD..." -> 1B 5B 31 3B 30 35 48 (tx_len 7), then 41 42 43 44 (tx_len 4), then IDLE.
- Truncation and len=0: PARM_COLS=16, col=14, len=8 -> 2 data bytes with tx_len 2. col=12, len=0 -> 1B 5B 30 3B 31 32 48 only.
- Reject: PARM_LINES=2, row=2, and separately op=10 -> o_err_cmd pulses for one enabled cycle, tx_enqueue stays 0, o_command_ready stays 1.
- Reset mid-DAT_RUN: assert i_srst asynchronously between enables -> outputs go to reset values immediately, and the boot wait restarts in full.
